// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit arbiter.
package usb_tx_pkg;

  // Width of one USB data word.
  localparam int WORD_W = 16;

  // Default idle limit between read_enable pulses (timeout build only).
  localparam int TIMEOUT_CYCLES_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SEND  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERROR = 3'd4
  } tx_state_t;

endpackage

// File: rtl/usb_rr_arbiter2.sv
// Two-way round-robin picker. r_prio names the requester favoured on the
// next pick; it moves to the other requester whenever a packet finishes.
module usb_rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  input  logic       i_last,
  output logic [1:0] o_pick
);

  logic r_prio;

  // Priority pointer: favour requester 0 out of reset, then the one after the last grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (i_advance) begin
      r_prio <= ~i_last;
    end
  end

  // One-hot pick of the favoured requester if it asks, else the other one.
  always_comb begin
    o_pick = 2'b00;
    if (!r_prio) begin
      if (i_req[0])      o_pick = 2'b01;
      else if (i_req[1]) o_pick = 2'b10;
    end else begin
      if (i_req[1])      o_pick = 2'b10;
      else if (i_req[0]) o_pick = 2'b01;
    end
  end

endmodule

// File: rtl/usb_tx_arbiter.sv
// Arbitrates two packet sources onto one USB transmitter.
// Optional feature: define USB_TX_ARB_TIMEOUT_EN to abort a packet when the
// transmitter stays silent for TIMEOUT_CYCLES cycles in SEND.
//
// Handshake: in SEND, tx_data carries the granted requester's head word; a
// cycle with read_enable high (and tx_error low) is a transfer, which pops
// that word (req_pop, same cycle) and decrements the remaining count.
// read_enable outside SEND is ignored.
module usb_tx_arbiter
  import usb_tx_pkg::*;
#(
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [LEN_W-1:0]  req_len0,
  input  logic [LEN_W-1:0]  req_len1,
  input  logic [WORD_W-1:0] req_data0,
  input  logic [WORD_W-1:0] req_data1,
  output logic [1:0]        req_pop,
  output logic [1:0]        grant,
  output logic [1:0]        done,
  output logic [1:0]        err,
  output logic [WORD_W-1:0] tx_data,
  output logic              transmit_start,
  output logic              transmit_empty,
  input  logic              read_enable,
  input  logic              tx_error,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  tx_state_t        r_state;
  logic [1:0]       r_grant;
  logic [LEN_W-1:0] r_cnt;
  logic [1:0]       w_pick;
  logic             w_advance;
  logic             w_read;
  logic             w_timeout;

  assign w_advance = (r_state == ST_DONE) || (r_state == ST_ERROR);

  usb_rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .i_req     (req),
    .i_advance (w_advance),
    .i_last    (r_grant[1]),
    .o_pick    (w_pick)
  );

  // An error in the same cycle as a read wins, so no word is consumed.
  assign w_read = (r_state == ST_SEND) && read_enable && !tx_error && (r_cnt != '0);

`ifdef USB_TX_ARB_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] r_idle;

  // Silence counter: cleared outside SEND and on every read, counts up in SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if ((r_state != ST_SEND) || read_enable) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end

  assign w_timeout = (r_state == ST_SEND) && !read_enable &&
                     (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // Main packet FSM: grant, word count and state all held here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_grant <= 2'b00;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_grant <= w_pick;
            r_cnt   <= w_pick[1] ? req_len1 : req_len0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (tx_error)            r_state <= ST_ERROR;
          else if (r_cnt == '0)    r_state <= ST_DONE;
          else                     r_state <= ST_SEND;
        end
        ST_SEND: begin
          if (tx_error || w_timeout) begin
            r_state <= ST_ERROR;
          end else if (w_read) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == LEN_W'(1)) r_state <= ST_DONE;
          end
        end
        ST_DONE, ST_ERROR: begin
          r_grant <= 2'b00;
          r_state <= ST_IDLE;
        end
        default: begin
          r_grant <= 2'b00;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from registered state; reset reaches outputs without a clock edge.
  always_comb begin
    grant          = r_grant;
    req_pop        = w_read ? r_grant : 2'b00;
    done           = (r_state == ST_DONE)  ? r_grant : 2'b00;
    err            = (r_state == ST_ERROR) ? r_grant : 2'b00;
    transmit_start = (r_state == ST_START);
    busy           = (r_state != ST_IDLE);
    transmit_empty = (r_state == ST_IDLE) || (r_state == ST_DONE) ||
                     (r_state == ST_ERROR) ||
                     ((r_state == ST_SEND) && (r_cnt == '0));
    tx_data        = '0;
    if (r_grant[0])      tx_data = req_data0;
    else if (r_grant[1]) tx_data = req_data1;
    dbg_state      = r_state;
  end

endmodule
